// File: rtl/retire_halt_monitor.sv
// Retirement counter, halt-idiom detector and cache write-back FIFO with drain-before-halt.
// Optional build macro: RETIRE_HALT_ON_ERROR_EN (trap/errcode also halt and set halt_err).
module retire_halt_monitor #(
    parameter int ADDR_W      = 32,
    parameter int OFFSET_W    = 5,
    parameter int LINE_W      = 256,
    parameter int ORDER_W     = 64,
    parameter int WB_DEPTH    = 8,
    parameter int HALT_REPEAT = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         commit_valid,
    input  logic [ADDR_W-1:0]            pc_rdata,
    input  logic [ADDR_W-1:0]            pc_wdata,
    input  logic                         trap,
    input  logic [15:0]                  errcode,
    input  logic                         pmem_write,
    input  logic                         pmem_resp,
    input  logic [ADDR_W-1:0]            pmem_address,
    input  logic [LINE_W-1:0]            pmem_wdata,
    input  logic                         wb_ready,
    output logic [ORDER_W-1:0]           order,
    output logic                         wb_valid,
    output logic [ADDR_W-OFFSET_W-1:0]   wb_addr,
    output logic [LINE_W-1:0]            wb_data,
    output logic [$clog2(WB_DEPTH):0]    wb_count,
    output logic                         wb_overflow,
    output logic                         halt,
    output logic                         halt_err
);

    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int TAG_W = ADDR_W - OFFSET_W;
    localparam int RPT_W = $clog2(HALT_REPEAT + 1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [ORDER_W-1:0] order_nxt;
    logic [RPT_W-1:0]   rpt_cnt, rpt_nxt;
    logic               err_nxt;

    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [PTR_W:0]     count;
    logic [TAG_W-1:0]   mem_addr [WB_DEPTH];
    logic [LINE_W-1:0]  mem_data [WB_DEPTH];

    logic push_req, push, pop, full, empty;
    logic self_loop, loop_done, error_hit;
    logic unused_bits;

    assign empty    = (count == '0);
    assign full     = (count == (PTR_W + 1)'(WB_DEPTH));
    assign push_req = pmem_write && pmem_resp && (state != HALTED);
    assign pop      = !empty && wb_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push     = push_req && (!full || pop);

    assign self_loop = commit_valid && (pc_wdata == pc_rdata);
    assign loop_done = self_loop && ((rpt_cnt + 1'b1) == RPT_W'(HALT_REPEAT));

`ifdef RETIRE_HALT_ON_ERROR_EN
    assign error_hit   = (commit_valid && trap) || (errcode != 16'h0000);
    assign unused_bits = ^pmem_address[OFFSET_W-1:0];
`else
    assign error_hit   = 1'b0;
    assign unused_bits = ^{pmem_address[OFFSET_W-1:0], trap, errcode};
`endif

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_nxt = state;
        order_nxt = order;
        rpt_nxt   = rpt_cnt;
        err_nxt   = halt_err;
        case (state)
            RUN: begin
                if (commit_valid) begin
                    order_nxt = order + 1'b1;
                    rpt_nxt   = self_loop ? rpt_cnt + 1'b1 : '0;
                end
                if (loop_done || error_hit) state_nxt = DRAIN;
                if (error_hit)              err_nxt   = 1'b1;
            end
            DRAIN: begin
                if (empty && !push_req) state_nxt = HALTED;
            end
            default: state_nxt = HALTED;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            order       <= '0;
            rpt_cnt     <= '0;
            halt_err    <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            wb_overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            order    <= order_nxt;
            rpt_cnt  <= rpt_nxt;
            halt_err <= err_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && full && !pop) wb_overflow <= 1'b1;
        end
    end

    // NOTE: the storage array is not reset; entries are only read while count says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= pmem_address[ADDR_W-1:OFFSET_W];
            mem_data[wr_ptr] <= pmem_wdata;
        end
    end

    assign wb_valid = !empty;
    assign wb_count = count;
    assign wb_addr  = mem_addr[rd_ptr];
    assign wb_data  = mem_data[rd_ptr];
    assign halt     = (state == HALTED);

endmodule

// File: tb/tb_retire_halt_monitor.sv
// Randomized + directed bench for retire_halt_monitor against a queue-based reference model.
module tb_retire_halt_monitor;

    localparam int ADDR_W = 32;
    localparam int OFF_W  = 5;
    localparam int LINE_W = 256;
    localparam int ORD_W  = 64;
    localparam int DEPTH  = 8;
    localparam int HR     = 3;
    localparam int TAG_W  = ADDR_W - OFF_W;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                commit_valid = 1'b0;
    logic [ADDR_W-1:0]   pc_rdata = '0;
    logic [ADDR_W-1:0]   pc_wdata = '0;
    logic                trap = 1'b0;
    logic [15:0]         errcode = '0;
    logic                pmem_write = 1'b0;
    logic                pmem_resp = 1'b0;
    logic [ADDR_W-1:0]   pmem_address = '0;
    logic [LINE_W-1:0]   pmem_wdata = '0;
    logic                wb_ready = 1'b0;
    logic [ORD_W-1:0]    order;
    logic                wb_valid;
    logic [TAG_W-1:0]    wb_addr;
    logic [LINE_W-1:0]   wb_data;
    logic [$clog2(DEPTH):0] wb_count;
    logic                wb_overflow, halt, halt_err;

    retire_halt_monitor #(
        .ADDR_W(ADDR_W), .OFFSET_W(OFF_W), .LINE_W(LINE_W), .ORDER_W(ORD_W),
        .WB_DEPTH(DEPTH), .HALT_REPEAT(HR)
    ) dut (
        .clk(clk), .rst(rst), .commit_valid(commit_valid), .pc_rdata(pc_rdata),
        .pc_wdata(pc_wdata), .trap(trap), .errcode(errcode), .pmem_write(pmem_write),
        .pmem_resp(pmem_resp), .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .wb_ready(wb_ready), .order(order), .wb_valid(wb_valid), .wb_addr(wb_addr),
        .wb_data(wb_data), .wb_count(wb_count), .wb_overflow(wb_overflow),
        .halt(halt), .halt_err(halt_err)
    );

    always #5 clk = ~clk;

    int n_compared = 0;
    int n_mismatched = 0;

    // Reference model: a queue of pending write-backs and plain flags for the run/drain/halt phase.
    typedef struct {
        logic [TAG_W-1:0]  addr;
        logic [LINE_W-1:0] data;
    } wb_t;

    wb_t        m_q[$];
    logic [63:0] m_order;
    int         m_run;
    bit         m_drain, m_halted, m_ovf, m_err;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        bit push_req, pop, err, self;
        int pre;
        if (rst) begin
            m_order = '0; m_run = 0; m_drain = 0; m_halted = 0; m_ovf = 0; m_err = 0;
            m_q.delete();
            return;
        end
        pre      = m_q.size();
        push_req = pmem_write && pmem_resp && !m_halted;
        pop      = (pre > 0) && wb_ready;
        err      = 0;
        self     = commit_valid && (pc_wdata == pc_rdata);
`ifdef RETIRE_HALT_ON_ERROR_EN
        err = (commit_valid && trap) || (errcode != 0);
`endif
        if (m_drain) begin
            if (pre == 0 && !push_req) begin
                m_drain  = 0;
                m_halted = 1;
            end
        end else if (!m_halted) begin
            if (commit_valid) begin
                m_order = m_order + 64'd1;
                m_run   = self ? m_run + 1 : 0;
            end
            if (err || (self && m_run == HR)) m_drain = 1;
            if (err) m_err = 1;
        end
        if (pop) void'(m_q.pop_front());
        if (push_req) begin
            if (pre < DEPTH || pop) m_q.push_back('{pmem_address[ADDR_W-1:OFF_W], pmem_wdata});
            else                    m_ovf = 1;
        end
    endtask

    task automatic compare_all();
        check("order", order, m_order);
        check("wb_valid", wb_valid, m_q.size() != 0);
        check("wb_count", wb_count, m_q.size());
        check("wb_overflow", wb_overflow, m_ovf);
        check("halt", halt, m_halted);
        check("halt_err", halt_err, m_err);
        if (m_q.size() != 0) begin
            check("wb_addr", wb_addr, m_q[0].addr);
            check("wb_data", wb_data, m_q[0].data);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] v;
        v = '0;
        for (int i = 0; i < LINE_W / 32; i++) v = {v[LINE_W-33:0], $urandom()};
        return v;
    endfunction

    task automatic idle();
        commit_valid = 0; trap = 0; errcode = '0; pmem_write = 0; pmem_resp = 0;
    endtask

    task automatic do_reset();
        idle();
        wb_ready = 0;
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic do_commit(input logic [31:0] pc, input logic [31:0] npc);
        commit_valid = 1; pc_rdata = pc; pc_wdata = npc;
        tick();
        commit_valid = 0;
    endtask

    task automatic do_write(input logic [31:0] a);
        pmem_write = 1; pmem_resp = 1; pmem_address = a; pmem_wdata = rand_line();
        tick();
        pmem_write = 0; pmem_resp = 0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_order", order, 64'd0);
        check("rst_halt", halt, 1'b0);
        check("rst_wb_valid", wb_valid, 1'b0);

        // Ten ordinary commits
        for (int i = 0; i < 10; i++) do_commit(32'h1000 + 32'(4 * i), 32'h1004 + 32'(4 * i));
        check("order_after_10", order, 64'd10);
        check("no_halt_after_10", halt, 1'b0);

        // Self-loop run broken by a normal commit, then three in a row
        do_commit(32'h60, 32'h60);
        do_commit(32'h64, 32'h68);
        do_commit(32'h60, 32'h60);
        do_commit(32'h60, 32'h60);
        check("no_halt_two_loops", halt, 1'b0);
        do_commit(32'h60, 32'h60);
        check("drain_t1_no_halt", halt, 1'b0);
        tick();
        check("halt_t2", halt, 1'b1);
        check("order_frozen", order, 64'd15);
        do_commit(32'h200, 32'h204);
        check("order_ignored_halted", order, 64'd15);

        // Drain holds halt until three queued write-backs leave in order
        do_reset();
        do_write(32'h100);
        do_write(32'h120);
        do_write(32'h140);
        for (int i = 0; i < HR; i++) do_commit(32'h80, 32'h80);
        for (int i = 0; i < 4; i++) tick();
        check("drain_holds", halt, 1'b0);
        check("drain_count", wb_count, 3);
        check("head_0", wb_addr, 27'h8);
        wb_ready = 1;
        tick();
        check("head_1", wb_addr, 27'h9);
        tick();
        check("head_2", wb_addr, 27'hA);
        tick();
        check("emptied_no_halt", halt, 1'b0);
        tick();
        check("halt_after_empty", halt, 1'b1);

        // Overflow on the ninth write into a full FIFO
        do_reset();
        for (int i = 0; i < 9; i++) do_write(32'h4000 + 32'(32 * i));
        check("full_count", wb_count, 8);
        check("overflow_set", wb_overflow, 1'b1);
        wb_ready = 1;
        for (int i = 0; i < 9; i++) tick();
        check("drained_count", wb_count, 0);
        check("overflow_sticky", wb_overflow, 1'b1);

        // Full FIFO with push and pop together
        do_reset();
        for (int i = 0; i < 8; i++) do_write(32'h8000 + 32'(32 * i));
        wb_ready = 1;
        do_write(32'h9000);
        check("full_pushpop_count", wb_count, 8);
        check("full_pushpop_no_ovf", wb_overflow, 1'b0);

        // Reset dominates while draining with a full FIFO
        wb_ready = 0;
        for (int i = 0; i < HR; i++) do_commit(32'h90, 32'h90);
        rst = 1; commit_valid = 1; pc_rdata = 32'h90; pc_wdata = 32'h94;
        pmem_write = 1; pmem_resp = 1; wb_ready = 1;
        tick();
        rst = 0; idle(); wb_ready = 0;
        check("rst_in_drain_count", wb_count, 0);
        check("rst_in_drain_order", order, 64'd0);

        // One-cycle error code
        do_reset();
        errcode = 16'h0001;
        tick();
        errcode = '0;
        for (int i = 0; i < 3; i++) tick();
`ifdef RETIRE_HALT_ON_ERROR_EN
        check("err_halt", halt, 1'b1);
        check("err_flag", halt_err, 1'b1);
`else
        check("err_ignored_halt", halt, 1'b0);
        check("err_ignored_flag", halt_err, 1'b0);
`endif

        // Randomized traffic with occasional resets
        for (int c = 0; c < 4000; c++) begin
            logic [31:0] pc;
            rst          = ($urandom_range(0, 149) == 0);
            commit_valid = $urandom_range(0, 1) == 1;
            pc           = {$urandom_range(0, 63), 2'b00};
            pc_rdata     = pc;
            pc_wdata     = ($urandom_range(0, 1) == 1) ? pc : pc + 32'd4;
            trap         = ($urandom_range(0, 63) == 0);
            errcode      = ($urandom_range(0, 199) == 0) ? 16'($urandom_range(1, 65535)) : 16'h0;
            pmem_write   = $urandom_range(0, 2) != 0;
            pmem_resp    = $urandom_range(0, 1) == 1;
            pmem_address = $urandom();
            pmem_wdata   = rand_line();
            wb_ready     = $urandom_range(0, 3) == 0;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/retire_halt_monitor.md
# retire_halt_monitor

Parametrised retirement and write-back monitor that sits beside the CPU and cache in simulation and FPGA-debug builds. It counts committed instructions (RVFI-style order), detects the halt idiom (a branch/jump to itself, optionally repeated N times), and buffers cache line write-backs to physical memory in a FIFO for a downstream checker. A drain state guarantees every write-back issued before halt is delivered before `halt` asserts.

## Interface
Parameters:
- `ADDR_W`, 32, physical byte-address width
- `OFFSET_W`, 5, line-offset bits stripped from captured addresses
- `LINE_W`, 256, cache line width in bits
- `ORDER_W`, 64, retirement counter width
- `WB_DEPTH`, 8, write-back FIFO entries (power of two, ≥2)
- `HALT_REPEAT`, 1, consecutive self-loop commits required to halt (≥1)

Ports (clock is `clk`; reset is `rst`; one clock; reset is synchronous and active-high):
- `clk` in 1: clock
- `rst` in 1: synchronous active-high reset
- `commit_valid` in 1: one instruction retires this cycle (CPU `load_pc`)
- `pc_rdata` in ADDR_W: PC of the retiring instruction
- `pc_wdata` in ADDR_W: next PC
- `trap` in 1: retiring instruction trapped
- `errcode` in 16: formal-monitor error code, nonzero = error
- `pmem_write` in 1: physical-memory write request
- `pmem_resp` in 1: physical-memory response
- `pmem_address` in ADDR_W: physical-memory address
- `pmem_wdata` in LINE_W: write line data
- `wb_ready` in 1: consumer accepts head FIFO entry
- `order` out ORDER_W: retired-instruction count
- `wb_valid` out 1: FIFO head valid
- `wb_addr` out ADDR_W-OFFSET_W: head line address (`pmem_address[ADDR_W-1:OFFSET_W]`)
- `wb_data` out LINE_W: head line data
- `wb_count` out $clog2(WB_DEPTH)+1: FIFO occupancy
- `wb_overflow` out 1: sticky, a write-back was dropped
- `halt` out 1: monitor halted
- `halt_err` out 1: halt caused by error

## Operation
- States: RUN, DRAIN, HALTED. Reset → RUN.
- RUN: on `commit_valid`, `order` += 1 (wraps modulo 2^ORDER_W). Self-loop commit (`pc_wdata == pc_rdata`) increments the repeat counter; any other commit clears it; cycles without commit leave it unchanged. When a self-loop commit brings the counter to HALT_REPEAT, go to DRAIN.
- DRAIN: `order` frozen, commits ignored. Writes still captured. When FIFO empty and no push this cycle → HALTED.
- HALTED: `halt`=1, terminal until `rst`. Captures and commits ignored; FIFO already empty.
- Capture: push {address tag, data} when `pmem_write && pmem_resp` in RUN or DRAIN. Pop when `wb_valid && wb_ready`.
- Full + push + pop same cycle: both happen, count unchanged. Full + push, no pop: entry dropped, `wb_overflow` set (sticky until `rst`). Empty: `wb_valid`=0, pop ignored. Push into empty FIFO is visible on `wb_valid` next cycle (no bypass).
- Pointers wrap modulo WB_DEPTH.

## Timing
- Reset values: `order`=0, `wb_valid`=0, `wb_count`=0, `wb_overflow`=0, `halt`=0, `halt_err`=0; `wb_addr`/`wb_data` don't-care while `wb_valid`=0.
- `order` updates one cycle after the `commit_valid` edge.
- Halt-triggering commit at cycle T: state=DRAIN at T+1; with empty FIFO, `halt`=1 at T+2.
- The halt-triggering commit itself increments `order`.
- `rst` in any state, including DRAIN with a full FIFO, clears everything at the next edge; reset dominates all other inputs.

## Configuration
- `RETIRE_HALT_ON_ERROR_EN` defined: in RUN, a commit with `trap`=1, or any cycle with `errcode != 0`, enters DRAIN and sets `halt_err`=1 (sticky). Error and self-loop in the same cycle → `halt_err`=1.
- Undefined: `trap`/`errcode` are ignored; `halt_err` is tied to 0.

## Test plan
- Reset, then 10 commits with `pc_wdata = pc_rdata + 4` → `order`=10, `halt`=0, state RUN.
- HALT_REPEAT=1, commit at PC 0x60 with `pc_wdata`=0x60 at cycle T, FIFO empty → `halt`=1 at T+2, `order` frozen at the pre-halt value +1.
- HALT_REPEAT=3: self-loop, normal commit, then 3 self-loops → halt only after the third consecutive self-loop.
- Three writes (addresses 0x100, 0x120, 0x140, `wb_ready`=0), then halt → state holds DRAIN. Raise `wb_ready` → entries pop in order 0x8, 0x9, 0xA; `halt` asserts one cycle after the FIFO empties.
- WB_DEPTH=8, 9 writes with `wb_ready`=0 → `wb_count`=8, `wb_overflow`=1, ninth entry absent. Full FIFO with push and pop in the same cycle → `wb_count` stays 8, no overflow.
- With `RETIRE_HALT_ON_ERROR_EN`, `errcode`=16'h0001 for one cycle → `halt_err`=1, `halt`=1 after drain. Without the macro → no halt, `halt_err`=0.
